// File: rtl/stream_frame_selector.sv
// Frame-aligned N:1 Avalon-ST video source selector; switches sources only between frames.
// Optional stall watchdog is built when STREAM_FRAME_SELECTOR_TIMEOUT_EN is defined.
module stream_frame_selector #(
   parameter int NUM_SRC     = 4,
   parameter int DATA_W      = 30,
   parameter int TIMEOUT_CYC = 500000
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [1:0]                sel_i,
   input  logic [NUM_SRC*DATA_W-1:0] data_i,
   input  logic [NUM_SRC-1:0]        sop_i,
   input  logic [NUM_SRC-1:0]        eop_i,
   input  logic [NUM_SRC-1:0]        valid_i,
   output logic [NUM_SRC-1:0]        ready_o,
   output logic [DATA_W-1:0]         data_o,
   output logic                      sop_o,
   output logic                      eop_o,
   output logic                      valid_o,
   input  logic                      ready_i,
   output logic [1:0]                active_sel_o,
   output logic [15:0]               frame_cnt_o,
   output logic                      timeout_o
);

   typedef enum logic {WAIT_SOP, STREAM} state_e;

   state_e      state_q, state_d;
   logic [1:0]  active_sel_q, active_sel_d;
   logic [15:0] frame_cnt_q, frame_cnt_d;

   logic [DATA_W-1:0] src_data;
   logic              src_sop, src_eop, src_valid;
   logic              src_ready;
   logic              accept;
   logic [1:0]        sel_next;

   // Out-of-range requests keep the current owner.
   assign sel_next = (int'(sel_i) < NUM_SRC) ? sel_i : active_sel_q;

   always_comb begin
      src_data  = '0;
      src_sop   = 1'b0;
      src_eop   = 1'b0;
      src_valid = 1'b0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (active_sel_q == 2'(k)) begin
            src_data  = data_i[k*DATA_W +: DATA_W];
            src_sop   = sop_i[k];
            src_eop   = eop_i[k];
            src_valid = valid_i[k];
         end
      end
   end

   assign data_o  = src_data;
   assign sop_o   = src_sop;
   assign eop_o   = src_eop;
   assign valid_o = rst_n & src_valid & ((state_q == STREAM) | src_sop);
   assign accept  = valid_o & ready_i;

   // Mid-frame junk ahead of a sop is drained regardless of downstream backpressure.
   assign src_ready = ((state_q == STREAM) | (src_valid & src_sop)) ? ready_i : 1'b1;

   always_comb begin
      for (int k = 0; k < NUM_SRC; k++) begin
         ready_o[k] = (active_sel_q == 2'(k)) ? src_ready : 1'b1;
      end
   end

`ifdef STREAM_FRAME_SELECTOR_TIMEOUT_EN
   localparam logic [19:0] WD_LIMIT = 20'(TIMEOUT_CYC - 1);

   logic [19:0] wd_cnt_q, wd_cnt_d;
   logic        timeout_q, timeout_d;
   logic        wd_expire;

   assign wd_expire = (state_q == STREAM) & ~accept & (wd_cnt_q == WD_LIMIT);
   assign wd_cnt_d  = ((state_q == STREAM) & ~accept & ~wd_expire) ? wd_cnt_q + 20'd1 : 20'd0;
   assign timeout_d = wd_expire;
   assign timeout_o = timeout_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wd_cnt_q  <= '0;
         timeout_q <= 1'b0;
      end else begin
         wd_cnt_q  <= wd_cnt_d;
         timeout_q <= timeout_d;
      end
   end
`else
   logic unused_timeout_cyc;
   assign unused_timeout_cyc = (TIMEOUT_CYC == 0);
   assign timeout_o          = 1'b0;
`endif

   // NOTE: every always_comb output gets a default first so no path infers a latch.
   always_comb begin
      state_d      = state_q;
      active_sel_d = active_sel_q;
      frame_cnt_d  = frame_cnt_q;
      case (state_q)
         WAIT_SOP: begin
            active_sel_d = sel_next;
            if (accept) begin
               if (src_eop) begin
                  frame_cnt_d = frame_cnt_q + 16'd1;
               end else begin
                  state_d      = STREAM;
                  active_sel_d = active_sel_q;
               end
            end
         end
         STREAM: begin
            if (accept && src_eop) begin
               frame_cnt_d  = frame_cnt_q + 16'd1;
               active_sel_d = sel_next;
               state_d      = WAIT_SOP;
            end
`ifdef STREAM_FRAME_SELECTOR_TIMEOUT_EN
            else if (wd_expire) begin
               active_sel_d = sel_next;
               state_d      = WAIT_SOP;
            end
`endif
         end
         default: state_d = WAIT_SOP;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= WAIT_SOP;
         active_sel_q <= 2'd0;
         frame_cnt_q  <= 16'd0;
      end else begin
         state_q      <= state_d;
         active_sel_q <= active_sel_d;
         frame_cnt_q  <= frame_cnt_d;
      end
   end

   assign active_sel_o = active_sel_q;
   assign frame_cnt_o  = frame_cnt_q;

endmodule

// File: tb/tb_stream_frame_selector.sv
// Directed bench for stream_frame_selector: frame-level model checked every cycle plus literal checks.
// Watchdog scenario follows STREAM_FRAME_SELECTOR_TIMEOUT_EN.
module tb_stream_frame_selector;

   localparam int N  = 3;
   localparam int W  = 30;
   localparam int TO = 16;

   logic           clk, rst_n;
   logic [1:0]     sel_i;
   logic [N*W-1:0] data_i;
   logic [N-1:0]   sop_i, eop_i, valid_i, ready_o;
   logic [W-1:0]   data_o;
   logic           sop_o, eop_o, valid_o, ready_i;
   logic [1:0]     active_sel_o;
   logic [15:0]    frame_cnt_o;
   logic           timeout_o;

   int n_vec = 0;
   int n_bad = 0;

   stream_frame_selector #(.NUM_SRC(N), .DATA_W(W), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .rst_n(rst_n), .sel_i(sel_i), .data_i(data_i),
      .sop_i(sop_i), .eop_i(eop_i), .valid_i(valid_i), .ready_o(ready_o),
      .data_o(data_o), .sop_o(sop_o), .eop_o(eop_o), .valid_o(valid_o),
      .ready_i(ready_i), .active_sel_o(active_sel_o), .frame_cnt_o(frame_cnt_o),
      .timeout_o(timeout_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Frame-level model: who owns the output, whether a frame is open, frames delivered.
   int m_owner, m_frames, m_idle;
   bit m_in_frame, m_to, m_acc;

   function automatic int pick();
      return (int'(sel_i) < N) ? int'(sel_i) : m_owner;
   endfunction

   always @(posedge clk) begin
      if (!rst_n) begin
         m_owner = 0; m_in_frame = 0; m_frames = 0; m_idle = 0; m_to = 0;
      end else begin
         m_acc = valid_i[m_owner] && (m_in_frame || sop_i[m_owner]) && ready_i;
         m_to  = 0;
         if (!m_in_frame) begin
            m_idle = 0;
            if (m_acc && !eop_i[m_owner]) m_in_frame = 1;
            else begin
               if (m_acc) m_frames++;
               m_owner = pick();
            end
         end else if (m_acc && eop_i[m_owner]) begin
            m_frames++; m_in_frame = 0; m_idle = 0; m_owner = pick();
         end else if (m_acc) begin
            m_idle = 0;
         end else begin
            m_idle++;
`ifdef STREAM_FRAME_SELECTOR_TIMEOUT_EN
            if (m_idle == TO) begin
               m_to = 1; m_in_frame = 0; m_idle = 0; m_owner = pick();
            end
`endif
         end
      end
   end

   logic         exp_valid;
   logic [N-1:0] exp_ready;

   always @(negedge clk) begin
      if (!rst_n) begin
         check("rst_valid_o", valid_o, 0);
         check("rst_active_sel_o", active_sel_o, 0);
         check("rst_frame_cnt_o", frame_cnt_o, 0);
         check("rst_timeout_o", timeout_o, 0);
      end else begin
         exp_valid = valid_i[m_owner] && (m_in_frame || sop_i[m_owner]);
         for (int k = 0; k < N; k++)
            exp_ready[k] = (k != m_owner) ? 1'b1 :
                           ((m_in_frame || (valid_i[k] && sop_i[k])) ? ready_i : 1'b1);
         check("valid_o", valid_o, exp_valid);
         if (exp_valid) begin
            check("data_o", data_o, data_i[m_owner*W +: W]);
            check("sop_o", sop_o, sop_i[m_owner]);
            check("eop_o", eop_o, eop_i[m_owner]);
         end
         check("ready_o", ready_o, exp_ready);
         check("active_sel_o", active_sel_o, m_owner);
         check("frame_cnt_o", frame_cnt_o, 16'(m_frames));
         check("timeout_o", timeout_o, m_to);
      end
   end

   task automatic set_src(input int k, input bit v, input bit s, input bit e, input int b);
      valid_i[k] = v; sop_i[k] = s; eop_i[k] = e;
      data_i[k*W +: W] = W'(k*256 + b);
   endtask

   task automatic idle_all();
      valid_i = '0; sop_i = '0; eop_i = '0;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      valid_i = '0; sop_i = '0; eop_i = '0; data_i = '0;
      sel_i = 2'd0; ready_i = 1'b1; rst_n = 1'b1;
      #2 rst_n = 1'b0;
      set_src(0, 1, 1, 0, 'h99);
      step();
      check("rst_gates_valid", valid_o, 0);
      check("rst_cnt_zero", frame_cnt_o, 0);
      step();
      idle_all(); rst_n = 1'b1;
      step();

      // 4-beat frame from source 0, zero-latency pass-through
      for (int b = 0; b < 4; b++) begin
         set_src(0, 1, b == 0, b == 3, b);
         #1;
         check("t1_valid", valid_o, 1);
         check("t1_data", data_o, b);
         step();
      end
      idle_all(); #1;
      check("t1_cnt", frame_cnt_o, 1);

      // sel_i changes mid-frame; switch waits for eop
      for (int b = 0; b < 4; b++) begin
         if (b == 1) sel_i = 2'd2;
         set_src(0, 1, b == 0, b == 3, b + 4);
         set_src(2, 1, 0, 0, b);
         #1;
         if (b >= 1) check("t2_hold_active", active_sel_o, 0);
         step();
      end
      check("t2_active_after_eop", active_sel_o, 2);
      check("t2_cnt", frame_cnt_o, 2);
      idle_all();
      set_src(2, 1, 1, 0, 'h10); #1;
      check("t2_next_sop_valid", valid_o, 1);
      check("t2_next_sop_data", data_o, 'h210);
      step();
      set_src(2, 1, 0, 1, 'h11); step();
      idle_all(); #1;
      check("t2_cnt_after", frame_cnt_o, 3);

      // Downstream stall for 5 cycles mid-frame
      set_src(2, 1, 1, 0, 'h20); step();
      ready_i = 1'b0;
      set_src(2, 1, 0, 0, 'h21);
      repeat (5) begin
         #1;
         check("t3_ready_stall", ready_o, 3'b011);
         check("t3_data_stable", data_o, 'h221);
         step();
      end
      ready_i = 1'b1; step();
      set_src(2, 1, 0, 1, 'h22); step();
      idle_all(); #1;
      check("t3_cnt", frame_cnt_o, 4);

      // Source 1 joins mid-frame: leading beats dropped until sop
      sel_i = 2'd1; step();
      check("t4_active", active_sel_o, 1);
      for (int b = 0; b < 3; b++) begin
         set_src(1, 1, 0, b == 2, b); #1;
         check("t4_drop", valid_o, 0);
         check("t4_ready", ready_o[1], 1);
         step();
      end
      set_src(1, 1, 1, 0, 'h10); #1;
      check("t4_sop_fwd", valid_o, 1);
      step();
      set_src(1, 1, 0, 1, 'h11); step();
      idle_all(); #1;
      check("t4_cnt", frame_cnt_o, 5);

      // Single-beat frame, then an illegal selection, then a double-sop frame
      sel_i = 2'd2;
      set_src(1, 1, 1, 1, 'h20); step();
      idle_all(); #1;
      check("t5_single_cnt", frame_cnt_o, 6);
      check("t5_single_active", active_sel_o, 2);
      sel_i = 2'd3; step(); step();
      check("t5_illegal_sel", active_sel_o, 2);
      for (int b = 0; b < 3; b++) begin
         set_src(2, 1, b < 2, b == 2, 'h30 + b); step();
      end
      idle_all(); #1;
      check("t5_double_sop_cnt", frame_cnt_o, 7);
      check("t5_keep_sel", active_sel_o, 2);

      // Reset pulsed mid-frame
      sel_i = 2'd2;
      set_src(2, 1, 1, 0, 'h40); step();
      set_src(2, 1, 0, 0, 'h41); step();
      set_src(2, 1, 0, 0, 'h42); rst_n = 1'b0; #1;
      check("t6_rst_valid", valid_o, 0);
      check("t6_rst_cnt", frame_cnt_o, 0);
      check("t6_rst_active", active_sel_o, 0);
      step();
      rst_n = 1'b1; step();
      set_src(2, 1, 0, 1, 'h43); #1;
      check("t6_tail_drop", valid_o, 0);
      step();
      set_src(2, 1, 1, 0, 'h50); step();
      set_src(2, 1, 0, 1, 'h51); step();
      idle_all(); #1;
      check("t6_cnt", frame_cnt_o, 1);
      check("t6_active", active_sel_o, 2);

      // Source goes silent for TO cycles inside a frame
      set_src(2, 1, 1, 0, 'h60); step();
      idle_all();
      repeat (TO) step();
`ifdef STREAM_FRAME_SELECTOR_TIMEOUT_EN
      check("t7_timeout_pulse", timeout_o, 1);
      step();
      check("t7_timeout_clear", timeout_o, 0);
      check("t7_cnt_kept", frame_cnt_o, 1);
      set_src(2, 1, 0, 1, 'h61); #1;
      check("t7_late_eop_drop", valid_o, 0);
      step();
      idle_all(); #1;
      check("t7_cnt_final", frame_cnt_o, 1);
`else
      check("t7_no_timeout", timeout_o, 0);
      step();
      set_src(2, 1, 0, 1, 'h61); #1;
      check("t7_late_eop_fwd", valid_o, 1);
      step();
      idle_all(); #1;
      check("t7_cnt_final", frame_cnt_o, 2);
`endif

      step();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
